// File: rtl/mux_arbiter8.sv
// mux_arbiter8: round-robin arbiter sharing one resource port among eight
// requesters. Holds the grant until the resource signals done, then returns
// the completion to the winner and rotates priority past it.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no transaction; arbitrate among req at the next edge
// BUSY  | grant/sel frozen, res_valid high, waiting for done
module mux_arbiter8 (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] grant,
   output logic [2:0] sel,
   output logic       res_valid,
   output logic [7:0] resp
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t     state, state_nxt;
   logic [2:0] ptr, ptr_nxt;
   logic [7:0] grant_nxt;
   logic [2:0] sel_nxt;
   logic [2:0] win;
   logic [2:0] idx;
   logic       found;

   // Winner search: walk offsets from 7 down to 0 so the lowest offset from ptr wins.
   always_comb begin
      win   = 3'd0;
      idx   = 3'd0;
      found = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         idx = ptr + 3'(i);
         if (req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   // Next-state logic: grant on IDLE with any request, release on done in BUSY.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      grant_nxt = grant;
      sel_nxt   = sel;
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt = BUSY;
               sel_nxt   = win;
               grant_nxt = 8'b1 << win;
            end
         end
         BUSY: begin
            if (done) begin
               state_nxt = IDLE;
               grant_nxt = 8'd0;
               ptr_nxt   = sel + 3'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and datapath registers; rst overrides any pending transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= 3'd0;
         grant <= 8'd0;
         sel   <= 3'd0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         grant <= grant_nxt;
         sel   <= sel_nxt;
      end
   end

   // Resource request tracks BUSY; completion is routed back combinationally.
   always_comb begin
      res_valid = (state == BUSY);
      resp      = (state == BUSY && done && !rst) ? grant : 8'd0;
   end

endmodule

// File: doc/mux_arbiter8.md
# mux_arbiter8

Round-robin arbiter that shares one downstream resource (e.g., a memory/cache port) among eight requesters. It drives the 3-bit select of the eight-input datapath mux in front of that resource. It holds a grant until the resource signals completion, then routes the completion back to the winning requester. It sits between the per-stage request sources and the shared resource port, and owns the mux select exclusively.

## Interface
- No parameters. Requester count is fixed at 8, matching a 3-bit select.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req  in  8  per-requester request level; bit i = requester i
- done  in  1  resource completion pulse, one cycle
- grant  out  8  one-hot registered grant; 0 when idle
- sel  out  3  registered mux select, equals index of granted requester
- res_valid  out  1  request to resource; high exactly while BUSY
- resp  out  8  one-hot completion to requester; equals grant when done in BUSY, else 0

## Operation
- State: IDLE, BUSY. Priority pointer ptr[2:0].
- Reset values: state IDLE, ptr 0, grant 0, sel 0, res_valid 0, resp 0.
- Search order: ptr, ptr+1, …, ptr+7, all mod 8. The first set req bit in that order is the winner w.
- IDLE, req != 0: at the next edge, state <= BUSY, sel <= w, grant <= 1<<w.
- IDLE, req == 0: hold. sel keeps its last value. grant stays 0.
- BUSY: res_valid = 1, decoded from state. grant and sel are frozen. Changes on req are ignored. Deasserting the granted req does not abort the transaction.
- BUSY with done = 1: resp = grant combinationally in the same cycle. At the next edge, state <= IDLE, grant <= 0, ptr <= sel+1 (7 wraps to 0).
- done in IDLE is ignored: resp stays 0, no state change.
- Requesters hold req high until they see their resp bit. The winner must drop req in the cycle after resp, or it re-enters arbitration at lowest priority.
- Starvation-free: a continuously asserted request is granted within 8 transactions.

## Timing
- Arbitration latency: req sampled in IDLE at edge k means grant/sel/res_valid are valid after edge k. Minimum is 1 cycle.
- Resource latency is unbounded. BUSY persists until done.
- done can arrive in the first BUSY cycle, giving a 1-cycle transaction.
- Turnaround: there is a mandatory IDLE cycle after each completion. Peak rate is one grant per (2 + resource latency) cycles.
- sel is stable for the whole BUSY interval and changes only on an IDLE→BUSY edge.
- rst has priority over everything. rst asserted mid-BUSY returns all state to reset values at that edge. A done coincident with rst is dropped. resp is 0 in the rst cycle.

## Test plan
- Single requester: after reset, req=0x08 → after 1 edge grant=0x08, sel=3, res_valid=1. done pulsed 4 cycles later gives resp=0x08 that cycle. Next cycle: grant=0, res_valid=0, ptr=4.
- Full contention: req=0xFF held, done returned 1 cycle into each BUSY. Grant sequence must be 0x01,0x02,…,0x80,0x01, with exactly one IDLE cycle between grants.
- Wrap-around: service requester 6 (ptr becomes 7), then req=0x41 → grant=0x01, sel=0. Then service requester 0 with req=0x40 still pending → grant=0x40.
- Fairness pair: req=0x81 held from reset → grants alternate 0x01, 0x80, 0x01. Neither side is granted twice in a row.
- Early drop and stray done: in BUSY on requester 2, drop req[2]. Grant must stay 0x04 until done. A done pulse in IDLE produces resp=0 and no state change.
- Reset mid-transaction: BUSY with sel=5, assert rst coincident with done → resp=0 that cycle. After the edge: grant=0, sel=0, res_valid=0, ptr=0. Then req=0x20 → grant=0x20.
